gate_bist: RTL

//  Built-in self-test controller for 2-input logic gate cells: the stimulus/check end of a gate DUT.

---
 rtl/gate_bist_pkg.sv | 31 +++
 rtl/gate_bist_ref.sv | 13 +
 rtl/gate_bist.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gate_bist_pkg.sv
// Shared definitions for the 2-input gate BIST controller: gate-function
// encodings, controller state codes and the expected-output function.
package gate_bist_pkg;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_NAND = 3'd2;
  localparam logic [2:0] GATE_NOR  = 3'd3;
  localparam logic [2:0] GATE_XOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;

  // ST_CFG is the one-cycle hop from an accepted illegal gate_sel to DONE.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_CFG    = 3'd4;

  function automatic logic exp_out(input logic [2:0] sel, input logic a, input logic b);
    case (sel)
      GATE_AND:  exp_out = a & b;
      GATE_OR:   exp_out = a | b;
      GATE_NAND: exp_out = ~(a & b);
      GATE_NOR:  exp_out = ~(a | b);
      GATE_XOR:  exp_out = a ^ b;
      GATE_XNOR: exp_out = ~(a ^ b);
      default:   exp_out = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_bist_ref.sv
// Combinational expected-value model for one gate function; reusable by benches.
module gate_ref_model
  import gate_bist_pkg::*;
(
  input  logic [2:0] sel_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       y_o
);

  assign y_o = exp_out(sel_i, a_i, b_i);

endmodule

// File: rtl/gate_bist.sv
// BIST controller sweeping a 2-input gate cell through its truth table.
// Optional first-fail capture outputs are enabled by GATE_BIST_FIRST_FAIL_EN.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             dut_out,
  output logic             test_a,
  output logic             test_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             cfg_err,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
`ifdef GATE_BIST_FIRST_FAIL_EN
  ,
  output logic             first_fail_vld,
  output logic [1:0]       first_fail
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PC_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic [2:0]       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fv_q, fv_d;
  logic             cfg_q, cfg_d;
  logic             exp_bit, accept, mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  gate_ref_model u_ref (
    .sel_i (sel_q),
    .a_i   (vec_q[1]),
    .b_i   (vec_q[0]),
    .y_o   (exp_bit)
  );

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch = (state_q == ST_SAMPLE) && (dut_out != exp_bit);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    err_d   = err_q;
    fv_d    = fv_q;
    cfg_d   = cfg_q;
    if (accept) begin
      sel_d = gate_sel;
      vec_d = 2'b00;
      cnt_d = CNT_INIT;
      pc_d  = '0;
      err_d = '0;
      fv_d  = '0;
      if (gate_sel > GATE_XNOR) begin
        cfg_d   = 1'b1;
        state_d = ST_CFG;
      end else begin
        cfg_d   = 1'b0;
        state_d = ST_SETTLE;
      end
    end else begin
      case (state_q)
        ST_CFG:    state_d = ST_DONE;
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_SAMPLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_d        = sat_inc(err_q);
            fv_d[vec_q]  = 1'b1;
          end
          // The 11->00 wrap also parks the stimulus at 00 once the run ends.
          vec_d = vec_q + 2'd1;
          cnt_d = CNT_INIT;
          if (vec_q == 2'b11) pc_d = pc_q + PC_W'(1);
          state_d = ((vec_q == 2'b11) && (pc_q == PC_LAST)) ? ST_DONE : ST_SETTLE;
        end
        ST_IDLE, ST_DONE: state_d = state_q;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      err_q   <= '0;
      fv_q    <= '0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      cfg_q   <= cfg_d;
    end
  end

  assign test_a    = vec_q[1];
  assign test_b    = vec_q[0];
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == '0) && !cfg_q;
  assign cfg_err   = cfg_q;
  assign err_count = err_q;
  assign fail_vec  = fv_q;

`ifdef GATE_BIST_FIRST_FAIL_EN
  logic       ffv_q, ffv_d;
  logic [1:0] ff_q, ff_d;

  always_comb begin
    ffv_d = ffv_q;
    ff_d  = ff_q;
    if (accept) begin
      ffv_d = 1'b0;
      ff_d  = 2'b00;
    end else if (mismatch && !ffv_q) begin
      ffv_d = 1'b1;
      ff_d  = vec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ffv_q <= 1'b0;
      ff_q  <= 2'b00;
    end else begin
      ffv_q <= ffv_d;
      ff_q  <= ff_d;
    end
  end

  assign first_fail_vld = ffv_q;
  assign first_fail     = ff_q;
`endif

endmodule
